fighter_sprite_fetch: RTL and testbench
=======================================

FIGHTER_SPRITE_FETCH -- requirements
Module: fighter_sprite_fetch

Interface
REQ-001 Parameter SPR_DIM, default 64, sprite width and height in pixels (power of two; ROM depth SPR_DIM*SPR_DIM = 4096).
REQ-002 Parameter ATK_FRAMES, default 12, duration in video frames of PUNCH, KICK and CROUCHPUNCH.
REQ-003 Parameter JUMP_FRAMES, default 32, duration in video frames of JUMP.
REQ-004 Parameter IDLE_FRAMES, default 16, STAND/STAND2 alternation period in frames.
REQ-005 clock  in  1  single system clock; all logic rising-edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 frame_tick  in  1  one-cycle pulse per video frame (vsync start).
REQ-008 cmd  in  7  held buttons {jump,kick,punch,block,crouch,left,right}, bit 6 = jump.
REQ-009 hp_zero  in  1  fighter health exhausted.
REQ-010 facing_left  in  1  mirror sprite horizontally.
REQ-011 char_x, char_y  in  10 each  sprite top-left screen coordinate.
REQ-012 draw_x, draw_y  in  10 each  current VGA pixel coordinate.
REQ-013 pose_sel  out  4  pose_t code; selects which pose ROM's q reaches rom_q.
REQ-014 rom_addr  out  12  address to all pose ROMs.
REQ-015 rom_q  in  4  palette index from the selected ROM, valid one cycle after rom_addr.
REQ-016 pixel_idx  out  4  palette index for the pixel presented two cycles earlier.
REQ-017 pixel_valid  out  1  sprite covers that pixel and index is non-zero.

Function
REQ-018 Poses SHALL be STAND, STAND2, MOVE, CROUCH, JUMP, PUNCH, KICK, BLOCK, CROUCHPUNCH, DEAD; pose_sel SHALL change only in the cycle after a frame_tick.
REQ-019 A 6-bit frame counter SHALL increment on each frame_tick and clear on every pose change.
REQ-020 hp_zero sampled at frame_tick SHALL force DEAD from any pose; DEAD SHALL be absorbing until reset.
REQ-021 PUNCH, KICK and CROUCHPUNCH SHALL hold for exactly ATK_FRAMES ticks, then return to neutral selection; they ignore cmd meanwhile.
REQ-022 JUMP SHALL hold for exactly JUMP_FRAMES ticks, ignoring cmd, then return to neutral selection.
REQ-023 Neutral selection at a tick SHALL use priority: jump > kick > punch (CROUCHPUNCH if crouch also held) > block > crouch > left|right (MOVE) > idle.
REQ-024 Idle SHALL enter STAND; STAND and STAND2 SHALL toggle every IDLE_FRAMES ticks while idle.
REQ-025 rel_x = draw_x - char_x and rel_y = draw_y - char_y SHALL be computed 11-bit two's complement; in_box when both lie in 0..SPR_DIM-1.
REQ-026 col SHALL be SPR_DIM-1-rel_x when facing_left, else rel_x; rom_addr = {rel_y[5:0], col[5:0]}, combinational from draw inputs; 0 when not in_box.
REQ-027 in_box SHALL be delayed one cycle to align with rom_q; pixel_idx and pixel_valid SHALL be registered, giving 2-cycle latency from draw_x/draw_y.
REQ-028 pixel_valid = delayed in_box AND rom_q != 0; pixel_idx SHALL be 0 whenever pixel_valid is 0.
REQ-029 Sprites partially off-screen (char_x > 640-SPR_DIM) SHALL clip with no wrap; differences crossing zero SHALL count as out of box.

Reset
REQ-030 On reset_n low: pose_sel = STAND, frame counter = 0, pixel_idx = 0, pixel_valid = 0, delay flag = 0.
REQ-031 Reset asserted mid-attack or mid-jump SHALL abort it; first post-reset tick SHALL apply neutral selection.

Structure
REQ-032 Package fighter_pkg SHALL hold pose_t enum (STAND = 0 ... DEAD = 9), SPR_DIM and the default durations.
REQ-033 Pose FSM and frame counter SHALL form sub-module fighter_pose_fsm; address/pipeline logic stays in the top.

Verification
REQ-034 Reset, idle, 40 ticks -> STAND ticks 1-15, STAND2 ticks 16-31, STAND from tick 32.
REQ-035 cmd punch for 1 tick, then jump held -> PUNCH for 12 ticks, then JUMP on tick 13.
REQ-036 char=(100,200), draw=(110,203), facing_left=0 -> rom_addr 0x0CA; facing_left=1 -> rom_addr 0x0F5; pixel_valid 2 cycles later iff rom_q != 0.
REQ-037 draw=(99,200) and (164,200) with char=(100,200) -> rom_addr 0, pixel_valid 0; char_x=620, draw_x=639 -> in_box, addr col 19.
REQ-038 hp_zero during KICK -> DEAD next tick; all cmd ignored afterwards; reset_n pulse -> STAND.

Source files
------------

// File: rtl/fighter_pkg.sv
// rtl/fighter_pkg.sv - shared pose codes, sprite geometry and default durations
package fighter_pkg;

    localparam int SPR_DIM         = 64;
    localparam int ATK_FRAMES_DEF  = 12;
    localparam int JUMP_FRAMES_DEF = 32;
    localparam int IDLE_FRAMES_DEF = 16;
    localparam int CNT_W           = 6;

    // Button positions inside cmd
    localparam int CMD_RIGHT  = 0;
    localparam int CMD_LEFT   = 1;
    localparam int CMD_CROUCH = 2;
    localparam int CMD_BLOCK  = 3;
    localparam int CMD_PUNCH  = 4;
    localparam int CMD_KICK   = 5;
    localparam int CMD_JUMP   = 6;

    typedef enum logic [3:0] {
        STAND       = 4'd0,
        STAND2      = 4'd1,
        MOVE        = 4'd2,
        CROUCH      = 4'd3,
        JUMP        = 4'd4,
        PUNCH       = 4'd5,
        KICK        = 4'd6,
        BLOCK       = 4'd7,
        CROUCHPUNCH = 4'd8,
        DEAD        = 4'd9
    } pose_t;

    // Button priority used whenever the fighter is free to pick a new pose
    function automatic pose_t neutral_pose(input logic [6:0] cmd);
        pose_t p;
        if (cmd[CMD_JUMP])                      p = JUMP;
        else if (cmd[CMD_KICK])                 p = KICK;
        else if (cmd[CMD_PUNCH])                p = cmd[CMD_CROUCH] ? CROUCHPUNCH : PUNCH;
        else if (cmd[CMD_BLOCK])                p = BLOCK;
        else if (cmd[CMD_CROUCH])               p = CROUCH;
        else if (cmd[CMD_LEFT] | cmd[CMD_RIGHT]) p = MOVE;
        else                                    p = STAND;
        return p;
    endfunction

endpackage

// File: rtl/fighter_sprite_fetch_if.sv
// rtl/fighter_sprite_fetch_if.sv - game-side inputs, pose ROM port and pixel output
interface fighter_sprite_fetch_if;
    import fighter_pkg::*;

    logic        frame_tick;
    logic [6:0]  cmd;
    logic        hp_zero;
    logic        facing_left;
    logic [9:0]  char_x;
    logic [9:0]  char_y;
    logic [9:0]  draw_x;
    logic [9:0]  draw_y;
    pose_t       pose_sel;
    logic [11:0] rom_addr;
    logic [3:0]  rom_q;
    logic [3:0]  pixel_idx;
    logic        pixel_valid;

    modport master (
        output frame_tick, cmd, hp_zero, facing_left,
        output char_x, char_y, draw_x, draw_y, rom_q,
        input  pose_sel, rom_addr, pixel_idx, pixel_valid
    );

    modport slave (
        input  frame_tick, cmd, hp_zero, facing_left,
        input  char_x, char_y, draw_x, draw_y, rom_q,
        output pose_sel, rom_addr, pixel_idx, pixel_valid
    );

endinterface

// File: rtl/fighter_pose_fsm.sv
// rtl/fighter_pose_fsm.sv - per-frame pose state machine with frame counter
module fighter_pose_fsm #(
    parameter int ATK_FRAMES  = fighter_pkg::ATK_FRAMES_DEF,
    parameter int JUMP_FRAMES = fighter_pkg::JUMP_FRAMES_DEF,
    parameter int IDLE_FRAMES = fighter_pkg::IDLE_FRAMES_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               frame_tick,
    input  logic [6:0]         cmd,
    input  logic               hp_zero,
    output fighter_pkg::pose_t pose
);
    import fighter_pkg::*;

    localparam logic [CNT_W-1:0] ATK_LAST  = CNT_W'(ATK_FRAMES - 1);
    localparam logic [CNT_W-1:0] JUMP_LAST = CNT_W'(JUMP_FRAMES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_FRAMES - 1);

    pose_t            pose_q, pose_d, sel;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timed, expired;

    // Next pose and frame count; everything moves only on a frame tick
    always_comb begin
        pose_d  = pose_q;
        cnt_d   = cnt_q;
        sel     = neutral_pose(cmd);
        timed   = (pose_q == JUMP) || (pose_q == PUNCH) ||
                  (pose_q == KICK) || (pose_q == CROUCHPUNCH);
        expired = (pose_q == JUMP) ? (cnt_q == JUMP_LAST) : (cnt_q == ATK_LAST);
        if (frame_tick) begin
            if (pose_q == DEAD) begin
                cnt_d = cnt_q + 1'b1;
            end else if (hp_zero) begin
                pose_d = DEAD;
                cnt_d  = '0;
            end else if (timed && !expired) begin
                cnt_d = cnt_q + 1'b1;
            end else if ((sel == STAND) && ((pose_q == STAND) || (pose_q == STAND2))) begin
                // Idle breathing animation: swap frames every IDLE_FRAMES ticks
                if (cnt_q == IDLE_LAST) begin
                    pose_d = (pose_q == STAND) ? STAND2 : STAND;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if ((sel == pose_q) && !timed) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                // A finished attack/jump re-selected while still held restarts it
                pose_d = sel;
                cnt_d  = '0;
            end
        end
    end

    // Pose and counter registers; reset aborts any attack or jump in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pose_q <= STAND;
            cnt_q  <= '0;
        end else begin
            pose_q <= pose_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pose = pose_q;

endmodule

// File: rtl/fighter_sprite_fetch.sv
// rtl/fighter_sprite_fetch.sv - pose selection plus sprite ROM address and pixel pipeline
module fighter_sprite_fetch #(
    parameter int SPR_DIM     = fighter_pkg::SPR_DIM,
    parameter int ATK_FRAMES  = fighter_pkg::ATK_FRAMES_DEF,
    parameter int JUMP_FRAMES = fighter_pkg::JUMP_FRAMES_DEF,
    parameter int IDLE_FRAMES = fighter_pkg::IDLE_FRAMES_DEF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    fighter_sprite_fetch_if.slave bus
);
    import fighter_pkg::*;

    localparam int         AW      = $clog2(SPR_DIM);
    localparam logic [9:0] DIM_LIM = 10'(SPR_DIM);

    pose_t         pose_w;
    logic [10:0]   rel_x, rel_y;
    logic [AW-1:0] col;
    logic          in_box;
    logic [11:0]   rom_addr_c;
    logic          in_box_q, in_box_d;
    logic [3:0]    pixel_idx_q, pixel_idx_d;
    logic          pixel_valid_q, pixel_valid_d;

    fighter_pose_fsm #(
        .ATK_FRAMES  (ATK_FRAMES),
        .JUMP_FRAMES (JUMP_FRAMES),
        .IDLE_FRAMES (IDLE_FRAMES)
    ) u_pose_fsm (
        .clock      (clock),
        .reset_n    (reset_n),
        .frame_tick (bus.frame_tick),
        .cmd        (bus.cmd),
        .hp_zero    (bus.hp_zero),
        .pose       (pose_w)
    );

    // Sprite-relative position; a negative difference (sign bit set) is outside
    // the box, so sprites hanging off the screen edge clip rather than wrap
    always_comb begin
        rel_x  = {1'b0, bus.draw_x} - {1'b0, bus.char_x};
        rel_y  = {1'b0, bus.draw_y} - {1'b0, bus.char_y};
        in_box = !rel_x[10] && (rel_x[9:0] < DIM_LIM) &&
                 !rel_y[10] && (rel_y[9:0] < DIM_LIM);
        // SPR_DIM-1-rel_x equals the bitwise complement inside the box
        col        = bus.facing_left ? ~rel_x[AW-1:0] : rel_x[AW-1:0];
        rom_addr_c = in_box ? 12'({rel_y[AW-1:0], col}) : 12'd0;
    end

    // Pixel stage: in_box delayed to line up with rom_q, then registered output
    always_comb begin
        in_box_d      = in_box;
        pixel_valid_d = in_box_q && (bus.rom_q != 4'd0);
        pixel_idx_d   = pixel_valid_d ? bus.rom_q : 4'd0;
    end

    // Pipeline registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_box_q      <= 1'b0;
            pixel_idx_q   <= 4'd0;
            pixel_valid_q <= 1'b0;
        end else begin
            in_box_q      <= in_box_d;
            pixel_idx_q   <= pixel_idx_d;
            pixel_valid_q <= pixel_valid_d;
        end
    end

    assign bus.pose_sel    = pose_w;
    assign bus.rom_addr    = rom_addr_c;
    assign bus.pixel_idx   = pixel_idx_q;
    assign bus.pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_fighter_sprite_fetch.sv
// tb/tb_fighter_sprite_fetch.sv - self-checking bench for fighter_sprite_fetch
module tb_fighter_sprite_fetch;
    import fighter_pkg::*;

    typedef struct {
        int         due;
        logic       valid;
        logic [3:0] idx;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    fighter_sprite_fetch_if bus();

    fighter_sprite_fetch #(
        .SPR_DIM     (64),
        .ATK_FRAMES  (12),
        .JUMP_FRAMES (32),
        .IDLE_FRAMES (16)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [3:0] rom_fn(input logic [3:0] p, input logic [11:0] a);
        return a[3:0] ^ a[7:4] ^ p;
    endfunction

    // Pose ROM model: one-cycle registered read of the selected pose
    always @(posedge clock) bus.rom_q <= rom_fn(4'(bus.pose_sel), bus.rom_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        bus.frame_tick = 1'b1;
        @(negedge clock);
        bus.frame_tick = 1'b0;
    endtask

    task automatic tick_check(input string tag, input pose_t exp);
        tick();
        check_eq(tag, 32'(bus.pose_sel), 32'(exp));
    endtask

    task automatic reset_pulse();
        @(negedge clock);
        reset_n = 1'b0;
        #2;
        check_eq("rst_pose", 32'(bus.pose_sel), 32'(STAND));
        check_eq("rst_valid", 32'(bus.pixel_valid), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic pop_due();
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check_eq("pix_valid", 32'(bus.pixel_valid), 32'(e.valid));
            check_eq("pix_idx", 32'(bus.pixel_idx), 32'(e.idx));
        end
    endtask

    task automatic pix_step(input int cx, input int cy, input int dx, input int dy, input bit fl);
        int         rx, ry, col;
        bit         inb;
        logic [11:0] addr;
        logic [3:0]  q;
        exp_t        e;
        @(negedge clock);
        cyc++;
        pop_due();
        bus.char_x      = 10'(cx);
        bus.char_y      = 10'(cy);
        bus.draw_x      = 10'(dx);
        bus.draw_y      = 10'(dy);
        bus.facing_left = fl;
        #1;
        rx   = dx - cx;
        ry   = dy - cy;
        inb  = (rx >= 0) && (rx < 64) && (ry >= 0) && (ry < 64);
        col  = fl ? (63 - rx) : rx;
        addr = inb ? 12'(ry * 64 + col) : 12'd0;
        check_eq($sformatf("rom_addr(%0d,%0d)-(%0d,%0d)f%0d", dx, dy, cx, cy, fl),
                 32'(bus.rom_addr), 32'(addr));
        q       = rom_fn(4'(STAND), addr);
        e.due   = cyc + 2;
        e.valid = inb && (q != 4'd0);
        e.idx   = e.valid ? q : 4'd0;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1);
    end

    initial begin
        int cx, cy, dx, dy;
        bus.frame_tick  = 1'b0;
        bus.cmd         = 7'd0;
        bus.hp_zero     = 1'b0;
        bus.facing_left = 1'b0;
        bus.char_x      = 10'd0;
        bus.char_y      = 10'd0;
        bus.draw_x      = 10'd700;
        bus.draw_y      = 10'd0;
        repeat (3) @(negedge clock);
        check_eq("reset_pose", 32'(bus.pose_sel), 32'(STAND));
        check_eq("reset_valid", 32'(bus.pixel_valid), 32'd0);
        check_eq("reset_idx", 32'(bus.pixel_idx), 32'd0);
        reset_n = 1'b1;

        // Idle breathing
        for (int k = 1; k <= 40; k++)
            tick_check($sformatf("idle_t%0d", k), (k < 16) ? STAND : (k < 32) ? STAND2 : STAND);

        // Punch then held jump
        bus.cmd = 7'b0010000;
        tick_check("punch_t1", PUNCH);
        bus.cmd = 7'b1000000;
        for (int k = 2; k <= 12; k++) tick_check($sformatf("punch_t%0d", k), PUNCH);
        tick_check("jump_t13", JUMP);
        bus.cmd = 7'd0;
        for (int k = 1; k <= 31; k++) tick_check($sformatf("jump_hold%0d", k), JUMP);
        tick_check("jump_end", STAND);

        // Priority and cmd ignored during attack
        bus.cmd = 7'b0010100;
        tick_check("cpunch_t1", CROUCHPUNCH);
        bus.cmd = 7'b0001110;
        for (int k = 2; k <= 12; k++) tick_check($sformatf("cpunch_t%0d", k), CROUCHPUNCH);
        tick_check("block_prio", BLOCK);
        bus.cmd = 7'b0000101;
        tick_check("crouch_prio", CROUCH);
        bus.cmd = 7'b0000011;
        tick_check("move", MOVE);
        bus.cmd = 7'b0111000;
        tick_check("kick_prio", KICK);

        // Death during kick
        bus.cmd = 7'd0;
        tick_check("kick_t2", KICK);
        bus.hp_zero = 1'b1;
        repeat (3) @(negedge clock);
        check_eq("no_tick_hold", 32'(bus.pose_sel), 32'(KICK));
        tick_check("dead", DEAD);
        bus.hp_zero = 1'b0;
        bus.cmd = 7'b1000000;
        for (int k = 0; k < 3; k++) tick_check("dead_abs", DEAD);
        bus.cmd = 7'h7F;
        tick_check("dead_abs_all", DEAD);
        reset_pulse();
        check_eq("dead_reset", 32'(bus.pose_sel), 32'(STAND));

        // Pose waits for a tick; reset aborts an attack
        bus.cmd = 7'b0100000;
        repeat (2) @(negedge clock);
        check_eq("wait_tick", 32'(bus.pose_sel), 32'(STAND));
        tick_check("kick_again", KICK);
        tick_check("kick_again2", KICK);
        reset_pulse();
        bus.cmd = 7'b0010000;
        tick_check("post_rst_neutral", PUNCH);
        bus.cmd = 7'd0;
        reset_pulse();

        // Address and pixel pipeline
        pix_step(100, 200, 110, 203, 0);
        pix_step(100, 200, 110, 203, 1);
        pix_step(100, 200, 112, 203, 0);
        pix_step(100, 200,  99, 200, 0);
        pix_step(100, 200, 164, 200, 0);
        pix_step(100, 200, 163, 263, 1);
        pix_step(100, 200, 100, 264, 0);
        pix_step(620,  10, 639,  12, 0);
        check_eq("clip_col19", 32'(bus.rom_addr[5:0]), 32'd19);
        pix_step(620,  10, 1023, 12, 0);
        pix_step(900,   0,  10,   5, 0);
        for (int i = 0; i < 30; i++) begin
            cx = $urandom_range(0, 700);
            cy = $urandom_range(0, 470);
            dx = cx + $urandom_range(0, 80) - 8;
            dy = cy + $urandom_range(0, 80) - 8;
            if (dx < 0) dx = 0;
            if (dy < 0) dy = 0;
            if (dx > 1023) dx = 1023;
            if (dy > 1023) dy = 1023;
            pix_step(cx, cy, dx, dy, $urandom_range(0, 1) == 1);
        end
        repeat (3) begin
            @(negedge clock);
            cyc++;
            pop_due();
        end
        check_eq("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
